// File: rtl/cr_huf_comp_sq_rd_if.sv
// Symbol-queue side bundles for cr_huf_comp_sq_rd: status/read data from the
// queue (s_sq_sa_intf) and the read request back to it (s_sa_sq_intf).
interface s_sq_sa_intf;
  logic        aempty;
  logic        empty;
  logic        eot;
  logic        sot;
  logic [2:0]  byte_vld;
  logic        tlast;
  logic        eob;
  logic [3:0]  seq_id;
  logic [63:0] data;

  modport master (
    output aempty, empty, eot, sot, byte_vld, tlast, eob, seq_id, data
  );
  modport slave (
    input aempty, empty, eot, sot, byte_vld, tlast, eob, seq_id, data
  );
endinterface

interface s_sa_sq_intf;
  logic rd;

  modport master (output rd);
  modport slave  (input rd);
endinterface

// File: rtl/cr_huf_comp_sq_rd.sv
// Symbol-queue reader: 2-cycle-latency reads into a credit-checked skid buffer,
// frame checker on popped words. Define CR_HUF_COMP_SQ_RD_STATS_EN for counters.
module cr_huf_comp_sq_rd #(
  parameter int SKID_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  s_sq_sa_intf.slave   sq_sa_intf,
  s_sa_sq_intf.master  sa_sq_intf,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [74:0]  out_word,
  output logic         framing_err,
  output logic [31:0]  frame_cnt,
  output logic [31:0]  word_cnt
);
  localparam int AW = $clog2(SKID_DEPTH);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  logic          run_reg;
  logic          rd_q1_reg;
  logic          rd_q2_reg;
  logic [AW:0]   occ_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [74:0]   skid_mem [SKID_DEPTH];
  state_t        state_reg;
  logic [3:0]    seq_reg;
  logic          framing_err_reg;

  logic          rd;
  logic          push;
  logic          pop;
  logic [AW+1:0] credit_used;
  logic [74:0]   in_word;
  logic [74:0]   head_word;
  logic          head_eot;
  logic          head_sot;
  logic [3:0]    head_seq;

  assign in_word = {sq_sa_intf.eot, sq_sa_intf.sot, sq_sa_intf.byte_vld, sq_sa_intf.tlast,
                    sq_sa_intf.eob, sq_sa_intf.seq_id, sq_sa_intf.data};

  // Words already requested but not yet captured still consume a skid slot.
  assign credit_used = {1'b0, occ_reg} + (AW+2)'(rd_q1_reg) + (AW+2)'(rd_q2_reg);

  // Status lags the queue by a cycle: aempty right after a read may mean it is now empty.
  assign rd = run_reg & ~sq_sa_intf.empty & ~(sq_sa_intf.aempty & rd_q1_reg)
            & (credit_used < (AW+2)'(SKID_DEPTH));
  assign sa_sq_intf.rd = rd;

  assign push      = rd_q2_reg;
  assign out_vld   = (occ_reg != '0);
  assign pop       = out_vld & out_rdy;
  assign head_word = skid_mem[rd_ptr_reg];
  assign out_word  = out_vld ? head_word : '0;
  assign head_eot  = head_word[74];
  assign head_sot  = head_word[73];
  assign head_seq  = head_word[67:64];
  assign framing_err = framing_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg    <= 1'b0;
      rd_q1_reg  <= 1'b0;
      rd_q2_reg  <= 1'b0;
      occ_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      run_reg   <= 1'b1;
      rd_q1_reg <= rd;
      rd_q2_reg <= rd_q1_reg;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + (AW+1)'(1);
        2'b01:   occ_reg <= occ_reg - (AW+1)'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid_mem[wr_ptr_reg] <= in_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      seq_reg         <= '0;
      framing_err_reg <= 1'b0;
    end else begin
      framing_err_reg <= 1'b0;
      if (pop) begin
        case (state_reg)
          ST_IDLE: begin
            if (!head_sot) begin
              framing_err_reg <= 1'b1;
            end else if (!head_eot) begin
              state_reg <= ST_FRAME;
              seq_reg   <= head_seq;
            end
          end
          ST_FRAME: begin
            // A new sot aborts the open frame; a sot+eot word is itself complete.
            if (head_sot) begin
              framing_err_reg <= 1'b1;
              seq_reg         <= head_seq;
              if (head_eot) state_reg <= ST_IDLE;
            end else begin
              if (head_seq != seq_reg) framing_err_reg <= 1'b1;
              if (head_eot) state_reg <= ST_IDLE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CR_HUF_COMP_SQ_RD_STATS_EN
  logic [31:0] frame_cnt_reg;
  logic [31:0] word_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= '0;
      word_cnt_reg  <= '0;
    end else if (pop) begin
      if (word_cnt_reg != 32'hFFFF_FFFF) word_cnt_reg <= word_cnt_reg + 32'd1;
      if (head_eot && (frame_cnt_reg != 32'hFFFF_FFFF)) frame_cnt_reg <= frame_cnt_reg + 32'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign word_cnt  = word_cnt_reg;
`else
  assign frame_cnt = '0;
  assign word_cnt  = '0;
`endif

endmodule
